// File: rtl/garage_door_supervisor_if.sv
// garage_door_supervisor_if: button/sensor inputs and motor/status outputs of the door supervisor
interface garage_door_supervisor_if;
   logic       activate;
   logic       up_max;
   logic       dn_max;
   logic       obstacle;
   logic       up_m;
   logic       dn_m;
   logic       fault;
   logic [2:0] door_state;
   modport master (output activate, up_max, dn_max, obstacle, input up_m, dn_m, fault, door_state);
   modport slave (input activate, up_max, dn_max, obstacle, output up_m, dn_m, fault, door_state);
endinterface

// File: rtl/garage_door_supervisor.sv
// garage_door_supervisor: debounced-button door FSM with run watchdog, obstacle reversal and fault latch; GARAGE_AUTO_CLOSE_EN adds auto-close from OPEN
module garage_door_supervisor #(
   parameter int DEB_CYCLES        = 4,
   parameter int RUN_TIMEOUT       = 1000,
   parameter int AUTO_CLOSE_CYCLES = 5000,
   parameter int CNT_W             = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   garage_door_supervisor_if.slave  bus
);
   localparam logic [2:0] STOPPED = 3'd0;
   localparam logic [2:0] MV_UP   = 3'd1;
   localparam logic [2:0] MV_DN   = 3'd2;
   localparam logic [2:0] OPEN    = 3'd3;
   localparam logic [2:0] CLOSED  = 3'd4;
   localparam logic [2:0] FAULT   = 3'd5;
   localparam int DW = $clog2(DEB_CYCLES + 1);

   logic [1:0]       sync;
   logic [DW-1:0]    deb_cnt;
   logic             deb;
   logic             act_pulse;
   logic             conflict;
   logic             run_done;
   logic             ac_done;
   logic [2:0]       state;
   logic [2:0]       nxt;
   logic [CNT_W-1:0] run_cnt;

   assign act_pulse = sync[1] && !deb && deb_cnt == DW'(DEB_CYCLES - 1);
   assign conflict  = bus.up_max && bus.dn_max;
   assign run_done  = (state == MV_UP || state == MV_DN) && run_cnt == CNT_W'(RUN_TIMEOUT - 1);
   assign bus.door_state = state;

   // two-flop synchronizer for the asynchronous push-button
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else sync <= {sync[0], bus.activate};

   // accept a new button level only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         deb     <= 1'b0;
         deb_cnt <= '0;
      end else if (sync[1] == deb) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
         deb     <= sync[1];
         deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;

   // door transitions; a limit switch always beats a simultaneous button press
   always_comb begin
      nxt = state;
      case (state)
         STOPPED: if (act_pulse) nxt = bus.dn_max ? MV_UP : MV_DN;
         CLOSED:  if (act_pulse) nxt = MV_UP;
         OPEN:    if (act_pulse || ac_done) nxt = MV_DN;
         MV_UP:   nxt = bus.up_max ? OPEN : run_done ? FAULT : act_pulse ? STOPPED : MV_UP;
         MV_DN:   nxt = bus.dn_max ? CLOSED : bus.obstacle ? MV_UP : run_done ? FAULT : act_pulse ? STOPPED : MV_DN;
         FAULT:   if (act_pulse && !conflict) nxt = STOPPED;
         default: nxt = STOPPED;
      endcase
      if (conflict && state != FAULT) nxt = FAULT;
   end

   // run watchdog restarts on every entry to a move state, including reversal
   always_ff @(posedge clk or posedge rst)
      if (rst) run_cnt <= '0;
      else run_cnt <= (nxt == MV_UP || nxt == MV_DN) && nxt == state ? run_cnt + 1'b1 : '0;

`ifdef GARAGE_AUTO_CLOSE_EN
   logic [CNT_W-1:0] ac_cnt;
   assign ac_done = !bus.obstacle && ac_cnt == CNT_W'(AUTO_CLOSE_CYCLES - 1);

   // auto-close timer counts only while parked open with a clear beam
   always_ff @(posedge clk or posedge rst)
      if (rst) ac_cnt <= '0;
      else ac_cnt <= state == OPEN && nxt == OPEN && !bus.obstacle ? ac_cnt + 1'b1 : '0;
`else
   assign ac_done = 1'b0;
`endif

   // state register and motor/fault outputs registered from the next state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= STOPPED;
         bus.up_m  <= 1'b0;
         bus.dn_m  <= 1'b0;
         bus.fault <= 1'b0;
      end else begin
         state     <= nxt;
         bus.up_m  <= nxt == MV_UP;
         bus.dn_m  <= nxt == MV_DN;
         bus.fault <= nxt == FAULT;
      end
endmodule

// File: tb/tb_garage_door_supervisor.sv
// tb_garage_door_supervisor: directed and randomized checks of the door supervisor against a behavioural model
module tb_garage_door_supervisor;
   localparam int DEB = 4, RT = 32, AC = 64;
   localparam int S_STOP = 0, S_UP = 1, S_DN = 2, S_OPEN = 3, S_CLOSED = 4, S_FAULT = 5;
`ifdef GARAGE_AUTO_CLOSE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0, failures = 0;
   int   m_state, m_on, m_open;
   bit   m_level, raw_d1, raw_d2;
   bit   hist[$];

   garage_door_supervisor_if bus();

   garage_door_supervisor #(.DEB_CYCLES(DEB), .RUN_TIMEOUT(RT), .AUTO_CLOSE_CYCLES(AC), .CNT_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = S_STOP;
      m_on    = 0;
      m_open  = 0;
      m_level = 0;
      raw_d1  = 0;
      raw_d2  = 0;
      hist.delete();
   endfunction

   // one clock edge of the reference: button seen two edges late, accepted after DEB equal samples
   function automatic void step();
      bit s, flip, pulse, conflict, moving;
      int nxt;
      s = raw_d2;
      raw_d2 = raw_d1;
      raw_d1 = bus.activate;
      hist.push_back(s);
      if (hist.size() > DEB) void'(hist.pop_front());
      flip = hist.size() == DEB;
      foreach (hist[i]) if (hist[i] == m_level) flip = 0;
      pulse = flip && !m_level;
      if (flip) m_level = !m_level;
      conflict = bus.up_max && bus.dn_max;
      moving = m_state == S_UP || m_state == S_DN;
      nxt = m_state;
      if (m_state != S_FAULT && conflict) nxt = S_FAULT;
      else if (m_state == S_STOP) begin
         if (pulse) nxt = bus.dn_max ? S_UP : S_DN;
      end else if (m_state == S_CLOSED) begin
         if (pulse) nxt = S_UP;
      end else if (m_state == S_OPEN) begin
         if (pulse || (AUTO && !bus.obstacle && m_open + 1 >= AC)) nxt = S_DN;
      end else if (m_state == S_UP) begin
         if (bus.up_max) nxt = S_OPEN;
         else if (m_on + 1 >= RT) nxt = S_FAULT;
         else if (pulse) nxt = S_STOP;
      end else if (m_state == S_DN) begin
         if (bus.dn_max) nxt = S_CLOSED;
         else if (bus.obstacle) nxt = S_UP;
         else if (m_on + 1 >= RT) nxt = S_FAULT;
         else if (pulse) nxt = S_STOP;
      end else if (pulse && !conflict) nxt = S_STOP;
      m_on   = (moving && nxt == m_state) ? m_on + 1 : 0;
      m_open = (m_state == S_OPEN && nxt == S_OPEN && !bus.obstacle) ? m_open + 1 : 0;
      m_state = nxt;
   endfunction

   task automatic cyc();
      @(posedge clk);
      step();
      #1;
      chk("up_m", int'(bus.up_m), int'(m_state == S_UP));
      chk("dn_m", int'(bus.dn_m), int'(m_state == S_DN));
      chk("fault", int'(bus.fault), int'(m_state == S_FAULT));
      chk("door_state", int'(bus.door_state), m_state);
   endtask

   task automatic press();
      bus.activate = 1'b1;
      repeat (8) cyc();
      bus.activate = 1'b0;
      repeat (8) cyc();
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hold;
      bus.activate = 0;
      bus.up_max   = 0;
      bus.dn_max   = 0;
      bus.obstacle = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_state", int'(bus.door_state), 0);
      chk("rst_up_m", int'(bus.up_m), 0);
      chk("rst_dn_m", int'(bus.dn_m), 0);
      chk("rst_fault", int'(bus.fault), 0);
      repeat (5) cyc();
      // closed door, button held: motor up after 2 sync + DEB debounce cycles
      bus.dn_max = 1;
      bus.activate = 1;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (bus.up_m && n == 0) n = i;
      end
      chk("act_latency", n, 2 + DEB);
      bus.activate = 0;
      bus.dn_max = 0;
      bus.up_max = 1;
      cyc();
      chk("open_up_m", int'(bus.up_m), 0);
      chk("open_state", int'(bus.door_state), S_OPEN);
      repeat (8) cyc();
      bus.activate = 1;
      repeat (3) cyc();
      bus.activate = 0;
      repeat (10) cyc();
      chk("glitch_state", int'(bus.door_state), S_OPEN);
      // close, obstacle reversal at move cycle 10, then run timeout
      bus.activate = 1;
      n = 0;
      while (!bus.dn_m && n < 20) begin cyc(); n++; end
      chk("mv_dn_start", int'(bus.dn_m), 1);
      bus.activate = 0;
      bus.up_max = 0;
      repeat (9) cyc();
      bus.obstacle = 1;
      cyc();
      bus.obstacle = 0;
      chk("rev_dn_m", int'(bus.dn_m), 0);
      chk("rev_up_m", int'(bus.up_m), 1);
      n = 0;
      while (bus.up_m && n < 100) begin cyc(); n++; end
      chk("run_len", n, RT);
      chk("timeout_fault", int'(bus.fault), 1);
      chk("timeout_state", int'(bus.door_state), S_FAULT);
      press();
      chk("fault_clear", int'(bus.fault), 0);
      chk("fault_clear_state", int'(bus.door_state), S_STOP);
      // reach CLOSED, then sensor conflict latches FAULT
      press();
      chk("stop_to_dn", int'(bus.dn_m), 1);
      bus.dn_max = 1;
      cyc();
      chk("closed_state", int'(bus.door_state), S_CLOSED);
      bus.up_max = 1;
      cyc();
      chk("conflict_state", int'(bus.door_state), S_FAULT);
      press();
      chk("conflict_hold", int'(bus.door_state), S_FAULT);
      bus.up_max = 0;
      press();
      chk("conflict_exit", int'(bus.door_state), S_STOP);
      // reopen and test auto-close behaviour
      bus.activate = 1;
      n = 0;
      while (!bus.up_m && n < 20) begin cyc(); n++; end
      bus.activate = 0;
      bus.dn_max = 0;
      bus.up_max = 1;
      cyc();
      chk("open2_state", int'(bus.door_state), S_OPEN);
`ifdef GARAGE_AUTO_CLOSE_EN
      n = 0;
      while (!bus.dn_m && n < 200) begin cyc(); n++; end
      chk("auto_close", n, AC);
      bus.obstacle = 1;
      cyc();
      bus.obstacle = 0;
      cyc();
      chk("reopen_state", int'(bus.door_state), S_OPEN);
      repeat (20) cyc();
      bus.obstacle = 1;
      repeat (11) cyc();
      bus.obstacle = 0;
      n = 0;
      while (!bus.dn_m && n < 200) begin cyc(); n++; end
      chk("auto_close_obs", n, AC);
`else
      repeat (200) cyc();
      chk("no_auto_close", int'(bus.door_state), S_OPEN);
`endif
      // asynchronous reset while closing
      if (!bus.dn_m) begin
         bus.activate = 1;
         n = 0;
         while (!bus.dn_m && n < 20) begin cyc(); n++; end
         bus.activate = 0;
      end
      chk("pre_rst_dn_m", int'(bus.dn_m), 1);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_dn_m", int'(bus.dn_m), 0);
      chk("async_rst_state", int'(bus.door_state), 0);
      bus.activate = 0;
      bus.up_max = 0;
      bus.dn_max = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      // randomized inputs against the model
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            bus.activate = 1'($urandom_range(1, 0));
            hold = $urandom_range(12, 1);
         end
         hold--;
         if ($urandom_range(15, 0) == 0) bus.up_max = !bus.up_max;
         if ($urandom_range(15, 0) == 0) bus.dn_max = !bus.dn_max;
         bus.obstacle = $urandom_range(19, 0) == 0;
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/garage_door_supervisor.md
Name: garage_door_supervisor

Overview:
- Top-level sequencing controller for the garage door motor.
- Debounces the raw Activate push-button into a single-cycle command and runs the door state machine from the limit switches (Up_max, Dn_max).
- Adds a run-time watchdog, obstacle reversal and fault latching, and drives the Up/Down motor enables.
- Sits between the board-level button/sensor inputs and the motor driver.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a new Activate level.
- RUN_TIMEOUT, 1000, maximum cycles a motor may stay enabled before a fault is declared.
- AUTO_CLOSE_CYCLES, 5000, cycles spent in OPEN before auto-close; used only with AUTO_CLOSE_EN.
- CNT_W, 16, width of the run and auto-close counters. Must satisfy 2^CNT_W > max(RUN_TIMEOUT, AUTO_CLOSE_CYCLES).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- Activate  in  1  raw push-button, asynchronous to CLK.
- Up_max  in  1  upper limit switch; 1 = door fully open.
- Dn_max  in  1  lower limit switch; 1 = door fully closed.
- Obstacle  in  1  beam-break sensor; 1 = obstruction present.
- Up_M  out  1  raise motor enable.
- Dn_M  out  1  lower motor enable.
- Fault  out  1  fault indicator.
- Door_State  out  3  state code: 0 STOPPED, 1 MV_UP, 2 MV_DN, 3 OPEN, 4 CLOSED, 5 FAULT.

Behaviour:
- Reset: state = STOPPED; Up_M = 0, Dn_M = 0, Fault = 0, Door_State = 0; all counters and synchronizer/debounce flops = 0.
- Outputs are registered and decoded from the next state:
  - Up_M = 1 only in MV_UP.
  - Dn_M = 1 only in MV_DN.
  - Fault = 1 only in FAULT.
  - Up_M and Dn_M are never both 1.
- Activate path:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level changes after DEB_CYCLES consecutive equal samples that differ from the current level.
  - act_pulse = one-cycle pulse on the debounced rising edge only.
  - Latency from raw rise to act_pulse = 2 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES produce no pulse.
- Transitions (evaluated each cycle, in priority order within a state):
  - Any state except FAULT: Up_max & Dn_max both 1 -> FAULT (sensor conflict; highest priority).
  - STOPPED: act_pulse -> MV_UP if Dn_max, else MV_DN.
  - CLOSED: act_pulse -> MV_UP.
  - OPEN: act_pulse -> MV_DN.
  - MV_UP, in priority order:
    - Up_max -> OPEN
    - run timeout -> FAULT
    - act_pulse -> STOPPED
  - MV_DN, in priority order:
    - Dn_max -> CLOSED
    - Obstacle -> MV_UP (reversal)
    - run timeout -> FAULT
    - act_pulse -> STOPPED
  - FAULT: act_pulse -> STOPPED, provided the sensor conflict is absent; otherwise remain in FAULT.
- Run counter:
  - Cleared on every entry into MV_UP or MV_DN, including reversal MV_DN -> MV_UP.
  - Increments each cycle while in a move state.
  - Timeout when count == RUN_TIMEOUT-1, so the motor enable is high for exactly RUN_TIMEOUT cycles.
  - Held at 0 outside move states. Never wraps.
- Obstacle outside MV_DN is ignored.
- act_pulse arriving in the same cycle as a limit hit: the limit wins, and the pulse is consumed (not queued).
- RST asserted mid-motion: motors off immediately (asynchronous); state returns to STOPPED.

Optional Feature:
- Macro: GARAGE_AUTO_CLOSE_EN.
- Defined:
  - An auto-close counter runs in OPEN and is cleared on entry to OPEN.
  - While Obstacle = 1, the counter is held at 0.
  - At count == AUTO_CLOSE_CYCLES-1 -> MV_DN.
  - act_pulse in OPEN still takes priority and goes -> MV_DN.
- Undefined:
  - No auto-close counter logic is built.
  - OPEN is left only via act_pulse or a sensor conflict.
  - AUTO_CLOSE_CYCLES is unused.

Test Plan (DEB_CYCLES=4, RUN_TIMEOUT=32, AUTO_CLOSE_CYCLES=64):
- Reset then hold inputs at 0 -> Up_M=0, Dn_M=0, Fault=0, Door_State=0.
- Dn_max=1, Activate high 10 cycles -> Up_M=1 exactly 6 cycles after the Activate rise. Then Up_max=1 (Dn_max=0) -> next cycle Up_M=0, Door_State=3. A 3-cycle Activate glitch -> no state change.
- From OPEN, Activate -> MV_DN. Obstacle=1 for 1 cycle at move cycle 10 -> Dn_M=0, Up_M=1 next cycle, run counter restarted (Up_M can last a further 32 cycles).
- MV_UP with no limit reached -> Up_M high exactly 32 cycles, then Fault=1, Door_State=5. Activate -> STOPPED, Fault=0.
- Up_max=1 and Dn_max=1 together while in CLOSED -> FAULT next cycle. Activate while the conflict persists -> stays in FAULT.
- GARAGE_AUTO_CLOSE_EN defined: enter OPEN, Obstacle=0 -> Dn_M=1 after 64 cycles. Repeat with Obstacle=1 from cycles 20 to 30 -> Dn_M=1 after 64 cycles counted from Obstacle release. Without the macro -> remains OPEN for at least 200 cycles.
- RST pulse while Dn_M=1 -> Dn_M=0 without waiting for a clock edge; Door_State=0.
